// File: rtl/hpc2_rnd_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : hpc2_rnd_source_if
//  Description : Seed and randomness handshake bundle for hpc2_rnd_source.
//                master modport = randomness producer, slave = seed source
//                plus randomness consumer.
//  Signals     : seed[31:0], seed_valid, seed_ready  - seed word handshake
//                r[rnd_total-1:0], r_valid, r_ready  - randomness handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface hpc2_rnd_source_if #(
    parameter int rnd_total = 1
);
    logic [31:0]          seed;
    logic                 seed_valid;
    logic                 seed_ready;
    logic [rnd_total-1:0] r;
    logic                 r_valid;
    logic                 r_ready;

    modport master (
        input  seed, seed_valid, r_ready,
        output seed_ready, r, r_valid
    );

    modport slave (
        output seed, seed_valid, r_ready,
        input  seed_ready, r, r_valid
    );
endinterface
`default_nettype wire

// File: rtl/hpc2_rnd_source.sv
`default_nettype none
// ============================================================================
//  Module      : hpc2_rnd_source
//  Description : Fresh-randomness producer for HPC2 masked AND gadgets.
//                A seedable 127-bit LFSR (x^127+x+1) that advances by
//                rnd_total sequence positions per accepted transfer.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - hpc2_rnd_source_if.master (seed in, randomness out)
//  Revision    : 1.0  initial release
// ============================================================================
module hpc2_rnd_source #(
    parameter int security_order = 1,
    parameter int n_gadgets      = 1,
    parameter int warmup         = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    hpc2_rnd_source_if.master      bus
);

    localparam int rnd       = security_order * (security_order + 1) / 2;
    localparam int rnd_total = rnd * n_gadgets;
    localparam int c_WCNT_W  = (warmup > 1) ? $clog2(warmup) : 1;

    generate
        if ((rnd_total > 127) || (rnd_total < 1)) begin : g_bad_width
            $error("hpc2_rnd_source: rnd_total must lie in 1..127");
        end
    endgenerate

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        WARMUP   = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t                state_q;
    logic [1:0]            k_q;
    logic [c_WCNT_W-1:0]   cnt_q;
    logic [126:0]          s_q;
    logic                  r_valid_q;

    logic [126:0]          s_adv_d;
    logic [126:0]          s_word_d;
    logic                  seed_ready_d;
    logic                  seed_acc_d;
    logic                  xfer_d;

    // Advance the window origin by rnd_total positions in one step.
    // Bits that fall off the top of the window are regenerated from the
    // recurrence b[n+127] = b[n+1] ^ b[n]; since rnd_total <= 127 every
    // tap needed is either an old state bit or an already-extended bit.
    function automatic logic [126:0] lfsr_advance(input logic [126:0] s);
        logic [127+rnd_total-1:0] e;
        e[126:0] = s;
        for (int j = 127; j < 127 + rnd_total; j++) begin
            e[j] = e[j-126] ^ e[j-127];
        end
        return e[rnd_total +: 127];
    endfunction

    always_comb begin
        s_adv_d = lfsr_advance(s_q);
    end

    // State image with the current seed word written into slot k_q.
    // Word 3 only fills bits 126:96 (seed bit 31 is dropped) and an
    // all-zero result is patched to a non-zero state, which would
    // otherwise lock the LFSR at zero forever.
    always_comb begin
        s_word_d = s_q;
        case (k_q)
            2'd0:    s_word_d[31:0]  = bus.seed;
            2'd1:    s_word_d[63:32] = bus.seed;
            2'd2:    s_word_d[95:64] = bus.seed;
            default: begin
                s_word_d[126:96] = bus.seed[30:0];
                if (s_word_d == '0) begin
                    s_word_d[0] = 1'b1;
                end
            end
        endcase
    end

    assign seed_ready_d = (state_q != WARMUP);
    assign seed_acc_d   = bus.seed_valid & seed_ready_d;
    assign xfer_d       = r_valid_q & bus.r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UNSEEDED;
            k_q       <= 2'd0;
            cnt_q     <= '0;
            s_q       <= '0;
            r_valid_q <= 1'b0;
        end else begin
            case (state_q)
                UNSEEDED: begin
                    if (seed_acc_d) begin
                        s_q     <= s_word_d;
                        k_q     <= 2'd1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (seed_acc_d) begin
                        s_q <= s_word_d;
                        if (k_q == 2'd3) begin
                            k_q   <= 2'd0;
                            cnt_q <= c_WCNT_W'(warmup - 1);
                            if (warmup == 0) begin
                                state_q   <= RUN;
                                r_valid_q <= 1'b1;
                            end else begin
                                state_q <= WARMUP;
                            end
                        end else begin
                            k_q <= k_q + 2'd1;
                        end
                    end
                end
                WARMUP: begin
                    s_q <= s_adv_d;
                    if (cnt_q == '0) begin
                        state_q   <= RUN;
                        r_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - c_WCNT_W'(1);
                    end
                end
                RUN: begin
                    // A reseed wins over the advance: the presented word is
                    // still consumed if r_ready is high, but bits 31:0 take
                    // the new seed and the rest are rewritten by words 1-3.
                    if (seed_acc_d) begin
                        s_q       <= s_word_d;
                        k_q       <= 2'd1;
                        state_q   <= LOAD;
                        r_valid_q <= 1'b0;
                    end else if (xfer_d) begin
                        s_q <= s_adv_d;
                    end
                end
                default: begin
                    state_q   <= UNSEEDED;
                    k_q       <= 2'd0;
                    r_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r          = s_q[rnd_total-1:0];
    assign bus.r_valid    = r_valid_q;
    assign bus.seed_ready = seed_ready_d;

endmodule
`default_nettype wire

// File: tb/tb_hpc2_rnd_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpc2_rnd_source
//  Description : Self-checking bench for hpc2_rnd_source. A rnd_total=1
//                instance is exercised from a vector table; a rnd_total=9
//                instance runs against a scoreboard fed by a bit-serial
//                reference of the x^127+x+1 sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hpc2_rnd_source;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hpc2_rnd_source_if #(.rnd_total(1)) b1 ();
    hpc2_rnd_source_if #(.rnd_total(9)) b9 ();

    hpc2_rnd_source #(.security_order(1), .n_gadgets(1), .warmup(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    hpc2_rnd_source #(.security_order(2), .n_gadgets(3), .warmup(4)) dut9 (
        .clk (clk),
        .rst (rst),
        .bus (b9)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        int          idx;
        logic        exp;
    } vec_t;

    vec_t       vecs [12];
    logic       bs [0:4095];
    logic [8:0] exp9 [$];
    bit         mon9  = 1'b0;
    bit         hold9 = 1'b0;
    logic [8:0] last_r9;
    int         xfers9 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: reset-state image from four seed words.
    function automatic logic [126:0] mk_state(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
        logic [126:0] s;
        s = {w3[30:0], w2, w1, w0};
        if (s == '0) s[0] = 1'b1;
        return s;
    endfunction

    // Reference: the sequence b[n], one bit at a time.
    task automatic gen_stream(input logic [126:0] s);
        for (int n = 0; n < 127; n++) bs[n] = s[n];
        for (int n = 127; n < 4096; n++) bs[n] = bs[n-126] ^ bs[n-127];
    endtask

    // Expected 9-bit words, starting after 4 warmup advances of 9 bits.
    task automatic push9(input int nwords);
        logic [8:0] w;
        exp9.delete();
        for (int j = 0; j < nwords; j++) begin
            for (int i = 0; i < 9; i++) w[i] = bs[36 + 9*j + i];
            exp9.push_back(w);
        end
    endtask

    // One clock: monitor/scoreboard at the falling edge, return 1 after rise.
    task automatic step();
        logic [8:0] w;
        @(negedge clk);
        if (mon9) begin
            if (hold9 && b9.r_valid) chk("r9_stable_when_stalled", 32'(b9.r), 32'(last_r9));
            hold9   = b9.r_valid && !b9.r_ready;
            last_r9 = b9.r;
            if (b9.r_valid && b9.r_ready) begin
                xfers9++;
                if (exp9.size() == 0) begin
                    chk("r9_scoreboard_underrun", 32'd1, 32'd0);
                end else begin
                    w = exp9.pop_front();
                    chk("r9_word", 32'(b9.r), 32'(w));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_seed(input bit d9, input logic [31:0] w, input logic v);
        if (d9) begin
            b9.seed = w; b9.seed_valid = v;
        end else begin
            b1.seed = w; b1.seed_valid = v;
        end
    endtask

    task automatic seed_range(input bit d9, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int first, input int last);
        logic [31:0] ws [4];
        ws = '{w0, w1, w2, w3};
        for (int k = first; k <= last; k++) begin
            drive_seed(d9, ws[k], 1'b1);
            step();
        end
        drive_seed(d9, 32'd0, 1'b0);
    endtask

    task automatic wait_valid(input bit d9, output int lat);
        lat = 0;
        while (!(d9 ? b9.r_valid : b1.r_valid) && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        bit          bubble;
        int          x0;
        logic [31:0] sw [4];
        logic [31:0] nw [4];
        logic [126:0] st;

        vecs[0]  = '{32'h1, 32'h0, 32'h0, 32'h0,          0,   1'b0};
        vecs[1]  = '{32'h1, 32'h0, 32'h0, 32'h0,          122, 1'b0};
        vecs[2]  = '{32'h1, 32'h0, 32'h0, 32'h0,          123, 1'b1};
        vecs[3]  = '{32'h1, 32'h0, 32'h0, 32'h0,          124, 1'b0};
        vecs[4]  = '{32'h1, 32'h0, 32'h0, 32'h0,          250, 1'b1};
        vecs[5]  = '{32'h0, 32'h0, 32'h0, 32'h0,          123, 1'b1};
        vecs[6]  = '{32'h0, 32'h0, 32'h0, 32'h0,          250, 1'b1};
        vecs[7]  = '{32'h0, 32'h0, 32'h0, 32'h80000000,   123, 1'b1};
        vecs[8]  = '{32'h0, 32'h0, 32'h0, 32'h80000000,   0,   1'b0};
        vecs[9]  = '{32'h2, 32'h0, 32'h0, 32'h0,          123, 1'b1};
        vecs[10] = '{32'h2, 32'h0, 32'h0, 32'h0,          125, 1'b0};
        vecs[11] = '{32'h0, 32'h0, 32'h0, 32'h40000000,   122, 1'b1};

        b1.seed = '0; b1.seed_valid = 1'b0; b1.r_ready = 1'b0;
        b9.seed = '0; b9.seed_valid = 1'b0; b9.r_ready = 1'b0;

        // Idle after reset with the consumer ready and no seed.
        do_reset();
        b1.r_ready = 1'b1;
        b9.r_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("idle_r_valid",    32'(b1.r_valid),    32'd0);
            chk("idle_r",          32'(b1.r),          32'd0);
            chk("idle_seed_ready", 32'(b1.seed_ready), 32'd1);
            chk("idle_r9_valid",   32'(b9.r_valid),    32'd0);
            step();
        end
        b9.r_ready = 1'b0;

        // Table: single-bit output at a given transfer index.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            b1.r_ready = 1'b1;
            seed_range(1'b0, vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3, 0, 3);
            wait_valid(1'b0, lat);
            chk("r1_latency", 32'(lat), 32'd4);
            bubble = 1'b0;
            for (int t = 0; t < vecs[v].idx; t++) begin
                step();
                if (!b1.r_valid) bubble = 1'b1;
            end
            chk("r1_no_bubble", 32'(bubble), 32'd0);
            chk("r1_bit", 32'(b1.r), 32'(vecs[v].exp));
            gen_stream(mk_state(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3));
            chk("r1_model_bit", 32'(b1.r), 32'(bs[4 + vecs[v].idx]));
        end
        b1.r_ready = 1'b0;

        // rnd_total=9: random seed, random back-pressure, scoreboarded.
        do_reset();
        for (int k = 0; k < 4; k++) sw[k] = $urandom;
        gen_stream(mk_state(sw[0], sw[1], sw[2], sw[3]));
        push9(200);
        hold9 = 1'b0;
        xfers9 = 0;
        mon9 = 1'b1;
        seed_range(1'b1, sw[0], sw[1], sw[2], sw[3], 0, 3);
        wait_valid(1'b1, lat);
        chk("r9_latency", 32'(lat), 32'd4);
        chk("r9_seed_ready_run", 32'(b9.seed_ready), 32'd1);
        for (int c = 0; c < 150; c++) begin
            b9.r_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("r9_enough_transfers", 32'(xfers9 > 40), 32'd1);

        // Reseed in RUN while a transfer completes in the same cycle.
        for (int k = 0; k < 4; k++) nw[k] = $urandom;
        b9.r_ready = 1'b1;
        drive_seed(1'b1, nw[0], 1'b1);
        x0 = xfers9;
        step();
        drive_seed(1'b1, 32'd0, 1'b0);
        chk("reseed_one_transfer", 32'(xfers9 - x0), 32'd1);
        chk("reseed_r_valid_drop", 32'(b9.r_valid), 32'd0);
        gen_stream(mk_state(nw[0], nw[1], nw[2], nw[3]));
        push9(60);
        seed_range(1'b1, nw[0], nw[1], nw[2], nw[3], 1, 3);
        wait_valid(1'b1, lat);
        chk("reseed_latency", 32'(lat), 32'd4);
        x0 = xfers9;
        for (int c = 0; c < 30; c++) step();
        chk("reseed_transfers", 32'(xfers9 - x0), 32'd30);
        b9.r_ready = 1'b0;
        mon9 = 1'b0;

        // Asynchronous reset in WARMUP.
        do_reset();
        seed_range(1'b1, 32'h5A5A01FF, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 0, 3);
        step();
        chk("warmup_seed_ready", 32'(b9.seed_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("warmup_rst_seed_ready", 32'(b9.seed_ready), 32'd1);
        chk("warmup_rst_r_valid",    32'(b9.r_valid),    32'd0);
        chk("warmup_rst_r",          32'(b9.r),          32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset in LOAD with k=2.
        seed_range(1'b1, 32'h000001AB, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1);
        chk("load_r_before_rst", 32'(b9.r), 32'h1AB);
        #2;
        rst = 1'b1;
        #1;
        chk("load_rst_seed_ready", 32'(b9.seed_ready), 32'd1);
        chk("load_rst_r_valid",    32'(b9.r_valid),    32'd0);
        chk("load_rst_r",          32'(b9.r),          32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean restart after the interrupted seed.
        for (int k = 0; k < 4; k++) sw[k] = $urandom;
        st = mk_state(sw[0], sw[1], sw[2], sw[3]);
        gen_stream(st);
        push9(40);
        hold9 = 1'b0;
        mon9 = 1'b1;
        b9.r_ready = 1'b1;
        seed_range(1'b1, sw[0], sw[1], sw[2], sw[3], 0, 3);
        wait_valid(1'b1, lat);
        chk("restart_latency", 32'(lat), 32'd4);
        x0 = xfers9;
        for (int c = 0; c < 20; c++) step();
        chk("restart_transfers", 32'(xfers9 - x0), 32'd20);
        mon9 = 1'b0;
        b9.r_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
